// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memories.
// master = sequencer side, slave = datapath/imem/dmem side.
interface cpu_control_fsm_if #(
  parameter int WIDTH_OPCODE    = 5,
  parameter int IMMEDIATE_WIDTH = 16,
  parameter int PC_WIDTH        = 16
);
  logic                       run;
  logic [WIDTH_OPCODE-1:0]    opcode;
  logic [IMMEDIATE_WIDTH-1:0] immediate;
  logic                       alu_zero;
  logic                       imem_ack;
  logic                       dmem_ack;
  logic [PC_WIDTH-1:0]        pc;
  logic                       imem_req;
  logic                       ir_load;
  logic [2:0]                 alu_op;
  logic                       ra_sel;
  logic                       rb_sel;
  logic                       alu_b_imm;
  logic [1:0]                 wb_sel;
  logic                       rf_we;
  logic                       flags_we;
  logic                       dmem_req;
  logic                       dmem_we;
  logic                       mdr_load;
  logic                       instr_retired;
  logic                       halted;

  modport master (
    input  run, opcode, immediate, alu_zero, imem_ack, dmem_ack,
    output pc, imem_req, ir_load, alu_op, ra_sel, rb_sel, alu_b_imm, wb_sel,
           rf_we, flags_we, dmem_req, dmem_we, mdr_load, instr_retired, halted
  );

  modport slave (
    output run, opcode, immediate, alu_zero, imem_ack, dmem_ack,
    input  pc, imem_req, ir_load, alu_op, ra_sel, rb_sel, alu_b_imm, wb_sel,
           rf_we, flags_we, dmem_req, dmem_we, mdr_load, instr_retired, halted
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns PC and halt, drives datapath strobes.
// State-derived strobes are registered; handshake-qualified ones (imem_req, ir_load, mdr_load, retire) are combinational.
module cpu_control_fsm #(
  parameter int                   WIDTH_OPCODE    = 5,
  parameter int                   IMMEDIATE_WIDTH = 16,
  parameter int                   PC_WIDTH        = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC        = '0
) (
  input  logic              clk,
  input  logic              reset,
  cpu_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       ra_sel;
    logic       rb_sel;
    logic       alu_b_imm;
    logic [1:0] wb_sel;
  } ctrl_t;

  localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(0);
  localparam logic [WIDTH_OPCODE-1:0] OP_LR   = WIDTH_OPCODE'(1);
  localparam logic [WIDTH_OPCODE-1:0] OP_LI   = WIDTH_OPCODE'(2);
  localparam logic [WIDTH_OPCODE-1:0] OP_SR   = WIDTH_OPCODE'(3);
  localparam logic [WIDTH_OPCODE-1:0] OP_MOVE = WIDTH_OPCODE'(4);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(5);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(6);
  localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(7);
  localparam logic [WIDTH_OPCODE-1:0] OP_CMP  = WIDTH_OPCODE'(8);
  localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(9);
  localparam logic [WIDTH_OPCODE-1:0] OP_OR   = WIDTH_OPCODE'(10);
  localparam logic [WIDTH_OPCODE-1:0] OP_NOT  = WIDTH_OPCODE'(11);
  localparam logic [WIDTH_OPCODE-1:0] OP_SHL  = WIDTH_OPCODE'(12);
  localparam logic [WIDTH_OPCODE-1:0] OP_SHR  = WIDTH_OPCODE'(13);
  localparam logic [WIDTH_OPCODE-1:0] OP_BNE  = WIDTH_OPCODE'(14);
  localparam logic [WIDTH_OPCODE-1:0] OP_BE   = WIDTH_OPCODE'(15);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_NOT  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  ctrl_t               ctrl_q;
  logic                dmem_req_q;
  logic                dmem_we_q;
  logic                rf_we_q;
  logic                flags_we_q;
  logic                halted_q;

  // EXEC controls and EXEC successor for the opcode currently in IR
  ctrl_t  dec_c;
  state_t dec_next;

  always_comb begin
    dec_c    = '0;
    dec_next = S_WB;
    case (bus.opcode)
      OP_LR, OP_SR: begin
        dec_c.alu_op    = ALU_ADD;
        dec_c.alu_b_imm = 1'b1;
        dec_next        = S_MEM;
      end
      OP_LI:   dec_c.wb_sel = WB_IMM;
      OP_MOVE: dec_c.alu_op = ALU_PASS;
      OP_NOT:  dec_c.alu_op = ALU_NOT;
      OP_ADD:  dec_c.alu_op = ALU_ADD;
      OP_SUB:  dec_c.alu_op = ALU_SUB;
      OP_AND:  dec_c.alu_op = ALU_AND;
      OP_OR:   dec_c.alu_op = ALU_OR;
      OP_ADDI: begin
        dec_c.alu_op    = ALU_ADD;
        dec_c.ra_sel    = 1'b1;
        dec_c.alu_b_imm = 1'b1;
      end
      OP_SHL: begin
        dec_c.alu_op    = ALU_SHL;
        dec_c.alu_b_imm = 1'b1;
      end
      OP_SHR: begin
        dec_c.alu_op    = ALU_SHR;
        dec_c.alu_b_imm = 1'b1;
      end
      OP_CMP, OP_BNE, OP_BE: begin
        dec_c.alu_op = ALU_SUB;
        dec_c.ra_sel = 1'b1;
        dec_c.rb_sel = 1'b1;
        dec_next     = S_FETCH;
      end
      default: ;
    endcase
  end

  logic is_nop, is_illegal, is_cmp, is_sr, is_lr, br_taken;
  logic [PC_WIDTH-1:0] pc_inc, br_tgt;

  assign is_nop     = (bus.opcode == OP_NOP);
  assign is_illegal = (bus.opcode > OP_BE);
  assign is_cmp     = (bus.opcode == OP_CMP);
  assign is_sr      = (bus.opcode == OP_SR);
  assign is_lr      = (bus.opcode == OP_LR);
  assign br_taken   = ((bus.opcode == OP_BNE) && !bus.alu_zero) ||
                      ((bus.opcode == OP_BE)  &&  bus.alu_zero);
  assign pc_inc     = pc_q + PC_WIDTH'(1);
  // signed cast sign-extends the offset; the add wraps modulo 2^PC_WIDTH
  assign br_tgt     = pc_inc + PC_WIDTH'($signed(bus.immediate));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc_q       <= RESET_PC;
      ctrl_q     <= '0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      flags_we_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      flags_we_q <= 1'b0;
      case (state)
        S_FETCH: if (bus.imem_req && bus.imem_ack) state <= S_DECODE;
        S_DECODE: begin
          if (is_nop) begin
            pc_q  <= pc_inc;
            state <= S_FETCH;
          end else if (is_illegal) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            ctrl_q     <= dec_c;
            flags_we_q <= is_cmp;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (dec_next)
            S_MEM: begin
              dmem_req_q <= 1'b1;
              dmem_we_q  <= is_sr;
              if (is_sr) ctrl_q.rb_sel <= 1'b1;
              state      <= S_MEM;
            end
            S_FETCH: begin
              pc_q   <= br_taken ? br_tgt : pc_inc;
              ctrl_q <= '0;
              state  <= S_FETCH;
            end
            default: begin
              rf_we_q <= 1'b1;
              state   <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_sr) begin
              pc_q   <= pc_inc;
              ctrl_q <= '0;
              state  <= S_FETCH;
            end else begin
              ctrl_q.wb_sel <= WB_MDR;
              rf_we_q       <= 1'b1;
              state         <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q   <= pc_inc;
          ctrl_q <= '0;
          state  <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.imem_req      = (state == S_FETCH) && bus.run;
  assign bus.ir_load       = bus.imem_req && bus.imem_ack;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.ra_sel        = ctrl_q.ra_sel;
  assign bus.rb_sel        = ctrl_q.rb_sel;
  assign bus.alu_b_imm     = ctrl_q.alu_b_imm;
  assign bus.wb_sel        = ctrl_q.wb_sel;
  assign bus.rf_we         = rf_we_q;
  assign bus.flags_we      = flags_we_q;
  assign bus.dmem_req      = dmem_req_q;
  assign bus.dmem_we       = dmem_we_q;
  assign bus.mdr_load      = (state == S_MEM) && is_lr && bus.dmem_ack;
  assign bus.halted        = halted_q;
  assign bus.instr_retired = ((state == S_DECODE) && is_nop) ||
                             ((state == S_EXEC) && (dec_next == S_FETCH)) ||
                             ((state == S_MEM) && is_sr && bus.dmem_ack) ||
                             (state == S_WB);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: models IR/decoder and imem locally, checks strobes per cycle.
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  cpu_control_fsm_if #(.WIDTH_OPCODE(5), .IMMEDIATE_WIDTH(16), .PC_WIDTH(16)) bus ();

  cpu_control_fsm #(.WIDTH_OPCODE(5), .IMMEDIATE_WIDTH(16), .PC_WIDTH(16), .RESET_PC(16'h0000))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [32:0] imem [16];
  logic [32:0] ir = '0;
  always @(posedge clk) if (bus.ir_load) ir <= imem[bus.pc[3:0]];
  assign bus.opcode    = ir[32:28];
  assign bus.immediate = ir[15:0];

  int nvec = 0;
  int nerr = 0;
  int nret = 0;
  always @(posedge clk) if (reset) nret <= 0; else if (bus.instr_retired) nret <= nret + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // step until the retire pulse (bounded), check cycle count and the PC after retirement
  task automatic wait_retire(input string tag, input int exp_cyc, input int exp_pc);
    int cyc = 1;
    while (bus.instr_retired !== 1'b1 && cyc < 40) begin step(); cyc++; end
    chk({tag, "_cycles"}, cyc, exp_cyc);
    step();
    chk({tag, "_pc"}, {16'h0, bus.pc}, exp_pc);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    int acc;
    bus.run = 1'b0; bus.alu_zero = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = '0;

    // run low at reset: idle, no request, then BE wraparound and CMP
    step(); step();
    chk("rst_pc", {16'h0, bus.pc}, 0);
    chk("rst_strobes", {bus.imem_req, bus.halted, bus.rf_we, bus.dmem_req, bus.instr_retired, bus.flags_we}, 0);
    reset = 1'b0; step();
    chk("idle_req_pc", {bus.imem_req, bus.pc}, 0);
    imem[0]  = 33'h0F000FFFD;
    imem[14] = 33'h000000000;
    imem[15] = 33'h0F0000001;
    imem[1]  = 33'h080000000;
    bus.run = 1'b1; bus.alu_zero = 1'b1; #1;
    chk("run_req", {bus.imem_req, bus.ir_load}, 2'b10);
    bus.imem_ack = 1'b1; #1;
    chk("run_ir_load", bus.ir_load, 1);
    wait_retire("be_back", 3, 16'hFFFE);
    wait_retire("nop_ffff", 2, 16'hFFFF);
    wait_retire("be_wrap", 3, 16'h0001);
    step();
    chk("cmp_dec", bus.flags_we, 0);
    step();
    chk("cmp_exec", {bus.flags_we, bus.alu_op, bus.ra_sel, bus.rb_sel, bus.instr_retired}, {1'b1, 3'd1, 3'b111});
    step();
    chk("cmp_after", {bus.flags_we, bus.pc}, {1'b0, 16'd2});

    // program loop with BNE back to 3
    imem[0] = 33'h021000000; imem[1] = 33'h022000000; imem[2] = 33'h02300000A;
    imem[3] = 33'h052210000; imem[4] = 33'h061000001; imem[5] = 33'h0E130FFFD;
    bus.alu_zero = 1'b0;
    do_reset();
    step(); step();
    chk("li_exec", {bus.wb_sel, bus.rf_we}, {2'd2, 1'b0});
    step();
    chk("li_wb", {bus.rf_we, bus.wb_sel, bus.instr_retired}, {1'b1, 2'd2, 1'b1});
    step();
    chk("li0_pc", {16'h0, bus.pc}, 1);
    wait_retire("li1", 4, 2);
    wait_retire("li2", 4, 3);
    wait_retire("add_a", 4, 4);
    wait_retire("addi_a", 4, 5);
    wait_retire("bne_a", 3, 3);
    wait_retire("add_b", 4, 4);
    step(); step();
    chk("addi_exec", {bus.alu_op, bus.ra_sel, bus.alu_b_imm, bus.rf_we}, {3'd0, 3'b110});
    step();
    chk("addi_wb", {bus.rf_we, bus.wb_sel, bus.alu_b_imm, bus.ra_sel, bus.instr_retired}, {1'b1, 2'd0, 3'b111});
    step();
    chk("addi_b_pc", {16'h0, bus.pc}, 5);
    wait_retire("bne_b", 3, 3);
    wait_retire("add_c", 4, 4);
    wait_retire("addi_c", 4, 5);
    bus.alu_zero = 1'b1;
    wait_retire("bne_fall", 3, 6);
    chk("retire_count", nret, 12);

    // LR with dmem_ack three cycles late
    imem[0] = 33'h011000010;
    do_reset();
    chk("lr_fetch", bus.ir_load, 1);
    step();
    chk("lr_dec", {bus.dmem_req, bus.rf_we, bus.mdr_load}, 0);
    step();
    chk("lr_exec", {bus.alu_op, bus.ra_sel, bus.alu_b_imm, bus.dmem_req}, {3'd0, 3'b010});
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lr_wait", {bus.dmem_req, bus.dmem_we, bus.mdr_load, bus.instr_retired}, 4'b1000);
      step();
    end
    bus.dmem_ack = 1'b1; #1;
    chk("lr_ack", {bus.dmem_req, bus.dmem_we, bus.mdr_load, bus.instr_retired}, 4'b1010);
    step();
    bus.dmem_ack = 1'b0;
    chk("lr_wb", {bus.rf_we, bus.wb_sel, bus.dmem_req, bus.mdr_load, bus.instr_retired}, {1'b1, 2'd1, 3'b001});
    step();
    chk("lr_done", {bus.rf_we, bus.pc}, {1'b0, 16'd1});

    // SR with immediate ack
    imem[0] = 33'h030100030;
    bus.dmem_ack = 1'b1;
    do_reset();
    acc = 0;
    for (int i = 0; i < 3; i++) begin acc += int'(bus.rf_we) + int'(bus.dmem_req); step(); end
    chk("sr_pre", acc, 0);
    chk("sr_mem", {bus.dmem_req, bus.dmem_we, bus.rb_sel, bus.rf_we, bus.instr_retired}, 5'b11101);
    step();
    chk("sr_done", {bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc}, {3'b000, 16'd1});
    bus.dmem_ack = 1'b0;

    // illegal opcode halts with PC frozen
    imem[0] = 33'h000000000; imem[1] = 33'h1F0000000;
    do_reset();
    wait_retire("nop_pre", 2, 1);
    chk("ill_fetch", bus.ir_load, 1);
    step();
    chk("ill_dec", bus.halted, 0);
    step();
    chk("ill_halt", {bus.halted, bus.pc}, {1'b1, 16'd1});
    acc = 0;
    for (int i = 0; i < 20; i++) begin acc += int'(bus.imem_req) + int'(bus.rf_we) + int'(bus.dmem_req); step(); end
    chk("halt_quiet", acc, 0);
    chk("halt_hold", {bus.halted, bus.pc}, {1'b1, 16'd1});
    reset = 1'b1; step();
    chk("halt_reset", {bus.halted, bus.pc}, 0);
    reset = 1'b0;

    // reset during a MEM wait
    imem[1] = 33'h011000010;
    wait_retire("nop_mem", 2, 1);
    step(); step(); step();
    chk("mem_wait", bus.dmem_req, 1);
    step();
    reset = 1'b1; step();
    chk("mem_reset", {bus.dmem_req, bus.imem_req, bus.mdr_load, bus.pc}, {3'b010, 16'd0});
    reset = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      acc += int'(bus.mdr_load) + int'(bus.rf_we) + int'(bus.dmem_req) + int'(bus.instr_retired);
    end
    chk("late_ack_ignored", acc, 0);
    chk("late_ack_pc", {16'h0, bus.pc}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
